// File: rtl/rr_grant_controller.sv
// Registered round-robin grant controller with one dead cycle between owners.
// Define RR_GRANT_HOLD_TIMEOUT_EN to add the hold watchdog (revoke + block).
module rr_grant_controller #(
  parameter int WIDTH    = 5,
  parameter int MAX_HOLD = 1024,
  parameter int IDX_W    = $clog2(WIDTH),
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             hostCLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] request,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout_pulse,
  output logic [IDX_W-1:0] timeout_idx
);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] last_idx, last_next;
  logic [WIDTH-1:0] eligible;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             release_evt;
  logic             timeout_evt;
  logic [WIDTH-1:0] grant_next;
  logic             valid_next;
  logic [IDX_W-1:0] idx_next;

`ifdef RR_GRANT_HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic [WIDTH-1:0] blocked;
  logic [WIDTH-1:0] block_set;
  logic             pulse_next;
  logic [IDX_W-1:0] tidx_next;

  assign eligible    = request & ~blocked;
  assign timeout_evt = (state == GRANTED) && request[grant_idx]
                       && (hold_cnt == CNT_W'(MAX_HOLD));
`else
  assign eligible      = request;
  assign timeout_evt   = 1'b0;
  assign timeout_pulse = 1'b0;
  assign timeout_idx   = '0;
`endif

  assign release_evt = (state == GRANTED) && !request[grant_idx];

  // Scan from last_idx+WIDTH down to last_idx+1 so the nearest eligible index overwrites the rest.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = WIDTH; k >= 1; k--) begin
      cand = (int'(last_idx) + k) % WIDTH;
      if (eligible[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge hostCLK) begin
    if (reset) begin
      state       <= IDLE;
      last_idx    <= IDX_W'(WIDTH - 1);
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      state       <= state_next;
      last_idx    <= last_next;
      grant       <= grant_next;
      grant_valid <= valid_next;
      grant_idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = GRANTED;
      GRANTED: if (release_evt || timeout_evt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_next = grant;
    valid_next = grant_valid;
    idx_next   = grant_idx;
    last_next  = last_idx;
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
    pulse_next = 1'b0;
    tidx_next  = timeout_idx;
    block_set  = '0;
`endif
    if (state == IDLE && win_found) begin
      grant_next          = '0;
      grant_next[win_idx] = 1'b1;
      valid_next          = 1'b1;
      idx_next            = win_idx;
      last_next           = win_idx;
    end else if (release_evt || timeout_evt) begin
      grant_next = '0;
      valid_next = 1'b0;
    end
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
    if (timeout_evt) begin
      pulse_next           = 1'b1;
      tidx_next            = grant_idx;
      block_set[grant_idx] = 1'b1;
    end
`endif
  end

`ifdef RR_GRANT_HOLD_TIMEOUT_EN
  // A blocked requester stays blocked only while it keeps its request high.
  always_ff @(posedge hostCLK) begin
    if (reset) begin
      hold_cnt      <= '0;
      blocked       <= '0;
      timeout_pulse <= 1'b0;
      timeout_idx   <= '0;
    end else begin
      blocked       <= (blocked & request) | block_set;
      timeout_pulse <= pulse_next;
      timeout_idx   <= tidx_next;
      if (state == IDLE && win_found)
        hold_cnt <= CNT_W'(1);
      else if (state == GRANTED && hold_cnt != CNT_W'(MAX_HOLD))
        hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rr_grant_controller.sv
// Directed self-checking bench for rr_grant_controller (WIDTH=5, MAX_HOLD=8).
module tb_rr_grant_controller;

  localparam int WIDTH    = 5;
  localparam int MAX_HOLD = 8;
  localparam int IDX_W    = $clog2(WIDTH);

  logic             hostCLK;
  logic             reset;
  logic [WIDTH-1:0] request;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             timeout_pulse;
  logic [IDX_W-1:0] timeout_idx;

  int checks = 0;
  int passes = 0;

  rr_grant_controller #(
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .hostCLK      (hostCLK),
    .reset        (reset),
    .request      (request),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .timeout_pulse(timeout_pulse),
    .timeout_idx  (timeout_idx)
  );

  initial hostCLK = 1'b0;
  always #5 hostCLK = ~hostCLK;

  // Drive inputs, let one rising edge sample them, then settle before any check.
  task automatic applyStimulus(input logic [WIDTH-1:0] req, input logic rst);
    request = req;
    reset   = rst;
    @(posedge hostCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic checkGrant(input string tag, input logic [WIDTH-1:0] exp_grant,
                            input int exp_idx);
    checkOutput({tag, " grant"}, 32'(grant), 32'(exp_grant));
    checkOutput({tag, " valid"}, 32'(grant_valid), 32'(exp_grant != '0));
    checkOutput({tag, " idx"}, 32'(grant_idx), 32'(exp_idx));
  endtask

  initial begin
    int bad;
    int exp_owner;
    request = '0;
    reset   = 1'b1;

    applyStimulus(5'b00000, 1'b1);
    applyStimulus(5'b00000, 1'b1);
    checkGrant("reset", 5'b00000, 0);
    checkOutput("reset tpulse", 32'(timeout_pulse), 32'd0);
    checkOutput("reset tidx", 32'(timeout_idx), 32'd0);

    applyStimulus(5'b00001, 1'b0);
    checkGrant("first grant", 5'b00001, 0);
    applyStimulus(5'b00001, 1'b1);
    checkOutput("midreset grant", 32'(grant), 32'd0);
    checkOutput("midreset valid", 32'(grant_valid), 32'd0);
    applyStimulus(5'b00001, 1'b0);
    checkGrant("post reset regrant", 5'b00001, 0);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("release grant", 32'(grant), 32'd0);

    applyStimulus(5'b00000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp_owner = i % WIDTH;
      for (int c = 0; c < 3; c++) begin
        applyStimulus(5'b11111, 1'b0);
        checkGrant($sformatf("rot%0d c%0d", i, c), WIDTH'(1 << exp_owner), exp_owner);
      end
      applyStimulus(5'b11111 & ~WIDTH'(1 << exp_owner), 1'b0);
      checkOutput($sformatf("rot%0d dead", i), 32'(grant), 32'd0);
    end
    applyStimulus(5'b00000, 1'b0);
    checkOutput("rot end", 32'(grant), 32'd0);

    applyStimulus(5'b00000, 1'b1);
    applyStimulus(5'b00100, 1'b0);
    checkGrant("prio own2", 5'b00100, 2);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("prio release", 32'(grant), 32'd0);
    applyStimulus(5'b00101, 1'b0);
    checkGrant("prio wrap", 5'b00001, 0);
    applyStimulus(5'b00000, 1'b0);

    applyStimulus(5'b00010, 1'b0);
    checkGrant("nopre own1", 5'b00010, 1);
    applyStimulus(5'b01010, 1'b0);
    checkGrant("nopre hold a", 5'b00010, 1);
    applyStimulus(5'b01010, 1'b0);
    checkGrant("nopre hold b", 5'b00010, 1);
    applyStimulus(5'b01000, 1'b0);
    checkOutput("nopre dead", 32'(grant), 32'd0);
    applyStimulus(5'b01000, 1'b0);
    checkGrant("nopre own3", 5'b01000, 3);
    applyStimulus(5'b10000, 1'b0);
    checkOutput("simul dead", 32'(grant), 32'd0);
    applyStimulus(5'b11000, 1'b0);
    checkGrant("reassert last", 5'b10000, 4);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("idx holds valid", 32'(grant_valid), 32'd0);
    checkOutput("idx holds", 32'(grant_idx), 32'd4);

`ifdef RR_GRANT_HOLD_TIMEOUT_EN
    applyStimulus(5'b00000, 1'b1);
    applyStimulus(5'b00010, 1'b0);
    checkGrant("wd c1", 5'b00010, 1);
    for (int c = 2; c <= MAX_HOLD; c++) begin
      applyStimulus(5'b00010, 1'b0);
      checkOutput($sformatf("wd c%0d grant", c), 32'(grant), 32'b00010);
      checkOutput($sformatf("wd c%0d tpulse", c), 32'(timeout_pulse), 32'd0);
    end
    applyStimulus(5'b00010, 1'b0);
    checkOutput("wd revoke grant", 32'(grant), 32'd0);
    checkOutput("wd revoke tpulse", 32'(timeout_pulse), 32'd1);
    checkOutput("wd revoke tidx", 32'(timeout_idx), 32'd1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(5'b00010, 1'b0);
      checkOutput($sformatf("wd blocked%0d grant", c), 32'(grant), 32'd0);
      checkOutput($sformatf("wd blocked%0d tpulse", c), 32'(timeout_pulse), 32'd0);
    end
    checkOutput("wd tidx holds", 32'(timeout_idx), 32'd1);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("wd drop", 32'(grant), 32'd0);
    applyStimulus(5'b00010, 1'b0);
    checkGrant("wd regrant", 5'b00010, 1);
    for (int c = 2; c <= MAX_HOLD; c++) applyStimulus(5'b00010, 1'b0);
    checkOutput("tie c8 grant", 32'(grant), 32'b00010);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("tie grant", 32'(grant), 32'd0);
    checkOutput("tie tpulse", 32'(timeout_pulse), 32'd0);
    applyStimulus(5'b00010, 1'b0);
    checkGrant("tie not blocked", 5'b00010, 1);
    applyStimulus(5'b00000, 1'b0);
`else
    applyStimulus(5'b00000, 1'b1);
    applyStimulus(5'b00001, 1'b0);
    checkGrant("long hold start", 5'b00001, 0);
    bad = 0;
    for (int c = 0; c < 5000; c++) begin
      applyStimulus(5'b00001, 1'b0);
      if (grant !== 5'b00001 || grant_valid !== 1'b1 || timeout_pulse !== 1'b0) bad++;
    end
    checkOutput("long hold bad cycles", 32'(bad), 32'd0);
    applyStimulus(5'b00000, 1'b0);
    checkOutput("long hold release", 32'(grant), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
